regfile_mp_sb: RTL and testbench
================================

Name: regfile_mp_sb

Overview:
- Parametrised multi-port integer register file for the NPC core, with a per-register busy scoreboard.
- Provides NR combinational read ports and NW synchronous write ports.
- Register 0 is hardwired to zero. Reset is asynchronous.
- Sits between decode/issue (reads, busy check, destination reservation) and writeback (data write, busy release).

Parameters:
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
- DATA_WIDTH, 64, register data width
- NR, 2, number of read ports (1..4)
- NW, 1, number of write ports (1..2)

Ports:
- clk  input  1  clock; all state updates on posedge
- rst_n  input  1  asynchronous active-low reset
- raddr  input  NR*ADDR_WIDTH  read addresses; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- rdata  output  NR*DATA_WIDTH  read data, same packing
- rbusy  output  NR  busy bit of each read address
- wen  input  NW  write enables
- waddr  input  NW*ADDR_WIDTH  write addresses
- wdata  input  NW*DATA_WIDTH  write data
- wclr  input  NW  with wen, release the busy bit of waddr
- iss_valid  input  1  reserve a destination register
- iss_rd  input  ADDR_WIDTH  register to mark busy
- busy_cnt  output  ADDR_WIDTH+1  number of busy registers

Behaviour:
- Reset: while rst_n = 0, all registers and all busy bits clear to 0 immediately (asynchronous). Outputs during and after reset: rdata = 0, rbusy = 0, busy_cnt = 0. Reset mid-operation discards any pending writes and reservations.
- Reads: combinational, zero latency, rdata_i = rf[raddr_i]. raddr = 0 always returns 0 with rbusy = 0.
- Writes: on posedge, if wen_j and waddr_j != 0, then rf[waddr_j] <= wdata_j. A write to address 0 is dropped.
- Same-cycle write collision (NW = 2, equal nonzero waddr): port NW-1 (highest index) wins. The data write and wclr apply from the winning port only.
- Busy set/clear on posedge:
  - iss_valid with iss_rd != 0 sets busy[iss_rd].
  - wen_j and wclr_j with waddr_j != 0 clears busy[waddr_j].
  - Set and clear to the same register in one cycle: set wins (new producer), so busy stays 1.
  - Clearing an idle register is legal and has no effect.
  - Setting an already-busy register is legal; it remains busy.
- rbusy_i = busy[raddr_i], combinational, reflecting the registered state (no same-cycle forwarding of iss_valid).
- busy_cnt:
  - Registered count updated in the same edge as busy bits.
  - Delta = +1 only when a set hits a 0 bit. Delta = -1 only for each clear that hits a 1 bit and is not overridden by a set.
  - Never exceeds 2**ADDR_WIDTH-1.
- Write without wclr updates data only and leaves busy unchanged (multi-cycle producers).

Optional Feature:
- Macro RF_BYPASS_EN.
- Defined:
  - A read whose nonzero raddr_i matches a same-cycle wen_j/waddr_j returns wdata_j combinationally, with the highest-index port winning.
  - If that port also has wclr_j asserted, rbusy_i = 0 in that cycle.
- Undefined: reads return the pre-edge register value and rbusy reflects the stored busy bit; the new value is visible the cycle after the write.

Test Plan:
- Reset release, then read every address on all ports -> rdata = 0, rbusy = 0, busy_cnt = 0.
- Write x5 = 0xDEAD_BEEF_0000_1234, next cycle read raddr0 = 5 -> that value. Write x0 = 0xFFFF, then read x0 -> 0.
- NW = 2, both ports write x7 (port0 0x11, port1 0x22) -> x7 = 0x22 next cycle.
- Busy lifecycle:
  - iss x3 -> rbusy = 1, busy_cnt = 1.
  - Write x3 with wclr -> rbusy = 0, busy_cnt = 0.
  - Same-cycle iss x3 and wclr x3 -> busy stays 1, busy_cnt unchanged from 1.
- Bypass: write x9 = 0x55 with wclr while reading x9. With RF_BYPASS_EN -> rdata = 0x55 and rbusy = 0 that cycle; without -> old value and old busy bit, then 0x55 next cycle.
- Assert rst_n low mid-cycle after x4 written and x4/x6 busy -> rdata and busy clear immediately without waiting for clk; busy_cnt = 0.

Source files
------------

// File: rtl/regfile_mp_sb_if.sv
// Bus bundle for regfile_mp_sb: read ports, write/release ports, issue reservation
// and the busy count. Master drives requests, slave is the register file.
interface regfile_mp_sb_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int NR         = 2,
    parameter int NW         = 1
);
    logic [NR*ADDR_WIDTH-1:0] raddr;
    logic [NR*DATA_WIDTH-1:0] rdata;
    logic [NR-1:0]            rbusy;
    logic [NW-1:0]            wen;
    logic [NW*ADDR_WIDTH-1:0] waddr;
    logic [NW*DATA_WIDTH-1:0] wdata;
    logic [NW-1:0]            wclr;
    logic                     iss_valid;
    logic [ADDR_WIDTH-1:0]    iss_rd;
    logic [ADDR_WIDTH:0]      busy_cnt;

    modport master (
        output raddr, wen, waddr, wdata, wclr, iss_valid, iss_rd,
        input  rdata, rbusy, busy_cnt
    );

    modport slave (
        input  raddr, wen, waddr, wdata, wclr, iss_valid, iss_rd,
        output rdata, rbusy, busy_cnt
    );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with per-register busy scoreboard; x0 reads zero.
// Optional macro RF_BYPASS_EN forwards same-cycle write data/release to the read ports.
module regfile_mp_sb #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int NR         = 2,
    parameter int NW         = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    regfile_mp_sb_if.slave    bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DEPTH-1:0][DATA_WIDTH-1:0] rf_q;
    logic [DEPTH-1:0]                 busy_q;
    logic [DEPTH-1:0]                 busy_next;
    logic [ADDR_WIDTH:0]              cnt_reg;
    logic [ADDR_WIDTH:0]              cnt_next;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign rf_q[gi]      = '0;
                assign busy_q[gi]    = 1'b0;
                assign busy_next[gi] = 1'b0;
            end else begin : g_live
                logic [DATA_WIDTH-1:0] data_reg;
                logic [DATA_WIDTH-1:0] wr_val;
                logic                  bsy_reg;
                logic                  wr_hit;
                logic                  clr_hit;
                logic                  set_hit;

                // Later ports overwrite earlier ones, so the highest index wins
                // both the data and the release decision.
                always_comb begin
                    wr_hit  = 1'b0;
                    clr_hit = 1'b0;
                    wr_val  = data_reg;
                    for (int j = 0; j < NW; j++) begin
                        if (bus.wen[j] && bus.waddr[j*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(gi)) begin
                            wr_hit  = 1'b1;
                            wr_val  = bus.wdata[j*DATA_WIDTH +: DATA_WIDTH];
                            clr_hit = bus.wclr[j];
                        end
                    end
                    set_hit = bus.iss_valid && (bus.iss_rd == ADDR_WIDTH'(gi));
                end

                // A new reservation overrides a same-cycle release.
                assign busy_next[gi] = set_hit | (bsy_reg & ~clr_hit);

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        data_reg <= '0;
                        bsy_reg  <= 1'b0;
                    end else begin
                        if (wr_hit) begin
                            data_reg <= wr_val;
                        end
                        bsy_reg <= busy_next[gi];
                    end
                end

                assign rf_q[gi]   = data_reg;
                assign busy_q[gi] = bsy_reg;
            end
        end
    endgenerate

    // Count follows the next busy vector, so it moves on the same edge as the bits.
    always_comb begin
        cnt_next = '0;
        for (int k = 0; k < DEPTH; k++) begin
            cnt_next = cnt_next + (ADDR_WIDTH+1)'(busy_next[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign bus.busy_cnt = cnt_reg;

    generate
        for (gi = 0; gi < NR; gi++) begin : g_rd
            logic [ADDR_WIDTH-1:0] ra;
            logic [DATA_WIDTH-1:0] rd;
            logic                  rb;

            always_comb begin
                ra = bus.raddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
                rd = rf_q[ra];
                rb = busy_q[ra];
`ifdef RF_BYPASS_EN
                for (int j = 0; j < NW; j++) begin
                    if (bus.wen[j] && ra != '0 && bus.waddr[j*ADDR_WIDTH +: ADDR_WIDTH] == ra) begin
                        rd = bus.wdata[j*DATA_WIDTH +: DATA_WIDTH];
                        rb = bus.wclr[j] ? 1'b0 : busy_q[ra];
                    end
                end
`endif
            end

            assign bus.rdata[gi*DATA_WIDTH +: DATA_WIDTH] = rd;
            assign bus.rbusy[gi]                          = rb;
        end
    endgenerate
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed self-checking bench for regfile_mp_sb built with NR=2, NW=2.
// Expected values are hand-computed constants; bypass expectations follow RF_BYPASS_EN.
module tb_regfile_mp_sb;
    localparam int AW = 5;
    localparam int DW = 64;
    localparam int NR = 2;
    localparam int NW = 2;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    regfile_mp_sb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR(NR), .NW(NW)) bus ();

    regfile_mp_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR(NR), .NW(NW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wen       = '0;
        bus.waddr     = '0;
        bus.wdata     = '0;
        bus.wclr      = '0;
        bus.iss_valid = 1'b0;
        bus.iss_rd    = '0;
    endtask

    task automatic set_raddr(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        bus.raddr = {a1, a0};
        #1;
    endtask

    task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic c);
        bus.wen[p]              = 1'b1;
        bus.waddr[p*AW +: AW]   = a;
        bus.wdata[p*DW +: DW]   = d;
        bus.wclr[p]             = c;
    endtask

    task automatic iss(input logic [AW-1:0] a);
        bus.iss_valid = 1'b1;
        bus.iss_rd    = a;
    endtask

    task automatic test_reset();
        logic [DW-1:0] d0, d1;
        idle();
        bus.raddr = '0;
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        for (int a = 0; a < 32; a++) begin
            set_raddr(AW'(a), AW'(31 - a));
            d0 = bus.rdata[0 +: DW];
            d1 = bus.rdata[DW +: DW];
            n_cmp++;
            if (d0 !== 64'd0 || d1 !== 64'd0 || bus.rbusy !== 2'b00) begin
                n_err++;
                $display("FAIL reset_read addr=%0d rdata0=%h rdata1=%h rbusy=%b required 0/0/00", a, d0, d1, bus.rbusy);
            end
        end
        n_cmp++;
        if (bus.busy_cnt !== 6'd0) begin
            n_err++;
            $display("FAIL reset_cnt busy_cnt=%0d required 0", bus.busy_cnt);
        end
        $display("reset: all addresses read on both ports");
    endtask

    task automatic test_write();
        idle();
        wr(0, 5'd5, 64'hDEAD_BEEF_0000_1234, 1'b0);
        step();
        idle();
        set_raddr(5'd5, 5'd0);
        n_cmp++;
        if (bus.rdata[0 +: DW] !== 64'hDEAD_BEEF_0000_1234) begin
            n_err++;
            $display("FAIL write_x5 rdata=%h required deadbeef00001234", bus.rdata[0 +: DW]);
        end
        $display("write x5: rdata=%h", bus.rdata[0 +: DW]);
        wr(0, 5'd0, 64'hFFFF, 1'b0);
        step();
        idle();
        set_raddr(5'd0, 5'd0);
        n_cmp++;
        if (bus.rdata[0 +: DW] !== 64'd0 || bus.rbusy[0] !== 1'b0) begin
            n_err++;
            $display("FAIL write_x0 rdata=%h rbusy=%b required 0/0", bus.rdata[0 +: DW], bus.rbusy[0]);
        end
        $display("write x0: rdata=%h", bus.rdata[0 +: DW]);
        wr(1, 5'd31, 64'h0123_4567_89AB_CDEF, 1'b0);
        step();
        idle();
        set_raddr(5'd5, 5'd31);
        n_cmp++;
        if (bus.rdata[DW +: DW] !== 64'h0123_4567_89AB_CDEF || bus.rdata[0 +: DW] !== 64'hDEAD_BEEF_0000_1234) begin
            n_err++;
            $display("FAIL write_x31_port1 rdata1=%h rdata0=%h required 0123456789abcdef/deadbeef00001234",
                     bus.rdata[DW +: DW], bus.rdata[0 +: DW]);
        end
        $display("write x31 via port1: rdata1=%h", bus.rdata[DW +: DW]);
    endtask

    task automatic test_busy();
        idle();
        set_raddr(5'd3, 5'd0);
        iss(5'd3);
        #1;
        n_cmp++;
        if (bus.rbusy[0] !== 1'b0) begin
            n_err++;
            $display("FAIL busy_no_forward rbusy=%b required 0", bus.rbusy[0]);
        end
        step();
        idle();
        #1;
        n_cmp++;
        if (bus.rbusy[0] !== 1'b1 || bus.busy_cnt !== 6'd1) begin
            n_err++;
            $display("FAIL busy_set rbusy=%b cnt=%0d required 1/1", bus.rbusy[0], bus.busy_cnt);
        end
        $display("iss x3: rbusy=%b cnt=%0d", bus.rbusy[0], bus.busy_cnt);
        iss(5'd3);
        step();
        idle();
        #1;
        n_cmp++;
        if (bus.rbusy[0] !== 1'b1 || bus.busy_cnt !== 6'd1) begin
            n_err++;
            $display("FAIL busy_reset_busy rbusy=%b cnt=%0d required 1/1", bus.rbusy[0], bus.busy_cnt);
        end
        wr(0, 5'd3, 64'h33, 1'b1);
        step();
        idle();
        #1;
        n_cmp++;
        if (bus.rbusy[0] !== 1'b0 || bus.busy_cnt !== 6'd0 || bus.rdata[0 +: DW] !== 64'h33) begin
            n_err++;
            $display("FAIL busy_clear rbusy=%b cnt=%0d rdata=%h required 0/0/33", bus.rbusy[0], bus.busy_cnt, bus.rdata[0 +: DW]);
        end
        $display("wclr x3: rbusy=%b cnt=%0d", bus.rbusy[0], bus.busy_cnt);
        wr(0, 5'd10, 64'hA, 1'b1);
        step();
        idle();
        #1;
        n_cmp++;
        if (bus.busy_cnt !== 6'd0) begin
            n_err++;
            $display("FAIL busy_clear_idle cnt=%0d required 0", bus.busy_cnt);
        end
        iss(5'd3);
        step();
        idle();
        iss(5'd3);
        wr(0, 5'd3, 64'h34, 1'b1);
        step();
        idle();
        #1;
        n_cmp++;
        if (bus.rbusy[0] !== 1'b1 || bus.busy_cnt !== 6'd1) begin
            n_err++;
            $display("FAIL busy_set_wins rbusy=%b cnt=%0d required 1/1", bus.rbusy[0], bus.busy_cnt);
        end
        $display("iss+wclr x3: rbusy=%b cnt=%0d", bus.rbusy[0], bus.busy_cnt);
        wr(1, 5'd3, 64'h35, 1'b1);
        step();
        idle();
        #1;
        n_cmp++;
        if (bus.rbusy[0] !== 1'b0 || bus.busy_cnt !== 6'd0) begin
            n_err++;
            $display("FAIL busy_clear_port1 rbusy=%b cnt=%0d required 0/0", bus.rbusy[0], bus.busy_cnt);
        end
    endtask

    task automatic test_collision();
        idle();
        wr(0, 5'd7, 64'h11, 1'b0);
        wr(1, 5'd7, 64'h22, 1'b0);
        step();
        idle();
        set_raddr(5'd7, 5'd7);
        n_cmp++;
        if (bus.rdata[0 +: DW] !== 64'h22 || bus.rdata[DW +: DW] !== 64'h22) begin
            n_err++;
            $display("FAIL collision_data rdata0=%h rdata1=%h required 22/22", bus.rdata[0 +: DW], bus.rdata[DW +: DW]);
        end
        $display("collision x7: rdata=%h", bus.rdata[0 +: DW]);
        iss(5'd8);
        step();
        idle();
        wr(0, 5'd8, 64'h81, 1'b1);
        wr(1, 5'd8, 64'h82, 1'b0);
        step();
        idle();
        set_raddr(5'd8, 5'd0);
        n_cmp++;
        if (bus.rdata[0 +: DW] !== 64'h82 || bus.rbusy[0] !== 1'b1 || bus.busy_cnt !== 6'd1) begin
            n_err++;
            $display("FAIL collision_wclr rdata=%h rbusy=%b cnt=%0d required 82/1/1", bus.rdata[0 +: DW], bus.rbusy[0], bus.busy_cnt);
        end
        $display("collision x8 (port0 wclr only): rbusy=%b cnt=%0d", bus.rbusy[0], bus.busy_cnt);
        wr(0, 5'd8, 64'h83, 1'b0);
        wr(1, 5'd8, 64'h84, 1'b1);
        step();
        idle();
        #1;
        n_cmp++;
        if (bus.rdata[0 +: DW] !== 64'h84 || bus.rbusy[0] !== 1'b0 || bus.busy_cnt !== 6'd0) begin
            n_err++;
            $display("FAIL collision_wclr_p1 rdata=%h rbusy=%b cnt=%0d required 84/0/0", bus.rdata[0 +: DW], bus.rbusy[0], bus.busy_cnt);
        end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] exp_d;
        logic          exp_b;
        idle();
        wr(0, 5'd9, 64'h11, 1'b0);
        iss(5'd9);
        step();
        idle();
        set_raddr(5'd9, 5'd0);
        wr(0, 5'd9, 64'h55, 1'b1);
        #1;
`ifdef RF_BYPASS_EN
        exp_d = 64'h55;
        exp_b = 1'b0;
`else
        exp_d = 64'h11;
        exp_b = 1'b1;
`endif
        n_cmp++;
        if (bus.rdata[0 +: DW] !== exp_d || bus.rbusy[0] !== exp_b) begin
            n_err++;
            $display("FAIL bypass_same_cycle rdata=%h rbusy=%b required %h/%b", bus.rdata[0 +: DW], bus.rbusy[0], exp_d, exp_b);
        end
        $display("bypass cycle x9: rdata=%h rbusy=%b", bus.rdata[0 +: DW], bus.rbusy[0]);
        step();
        idle();
        #1;
        n_cmp++;
        if (bus.rdata[0 +: DW] !== 64'h55 || bus.rbusy[0] !== 1'b0 || bus.busy_cnt !== 6'd0) begin
            n_err++;
            $display("FAIL bypass_next_cycle rdata=%h rbusy=%b cnt=%0d required 55/0/0", bus.rdata[0 +: DW], bus.rbusy[0], bus.busy_cnt);
        end
    endtask

    task automatic test_async_reset();
        idle();
        wr(0, 5'd4, 64'hABCD, 1'b0);
        iss(5'd4);
        step();
        idle();
        iss(5'd6);
        step();
        idle();
        set_raddr(5'd4, 5'd6);
        n_cmp++;
        if (bus.rdata[0 +: DW] !== 64'hABCD || bus.rbusy !== 2'b11 || bus.busy_cnt !== 6'd2) begin
            n_err++;
            $display("FAIL pre_reset rdata=%h rbusy=%b cnt=%0d required abcd/11/2", bus.rdata[0 +: DW], bus.rbusy, bus.busy_cnt);
        end
        wr(1, 5'd6, 64'h66, 1'b0);
        iss(5'd12);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.rdata[0 +: DW] !== 64'd0 || bus.rbusy !== 2'b00 || bus.busy_cnt !== 6'd0) begin
            n_err++;
            $display("FAIL async_reset rdata=%h rbusy=%b cnt=%0d required 0/00/0", bus.rdata[0 +: DW], bus.rbusy, bus.busy_cnt);
        end
        $display("async reset mid-cycle: rdata=%h rbusy=%b cnt=%0d", bus.rdata[0 +: DW], bus.rbusy, bus.busy_cnt);
        step();
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        set_raddr(5'd6, 5'd12);
        n_cmp++;
        if (bus.rdata[0 +: DW] !== 64'd0 || bus.rbusy !== 2'b00 || bus.busy_cnt !== 6'd0) begin
            n_err++;
            $display("FAIL reset_discard rdata=%h rbusy=%b cnt=%0d required 0/00/0", bus.rdata[0 +: DW], bus.rbusy, bus.busy_cnt);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle();
        bus.raddr = '0;
        test_reset();
        test_write();
        test_busy();
        test_collision();
        test_bypass();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
